// File: rtl/pcs_rx_block_lock_pkg.sv
// rtl/pcs_rx_block_lock_pkg.sv - shared types and constants for 10GBASE-R rx block lock
package gtype;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // 125 us at 322.265625 MHz
    localparam int BER_WINDOW_322M = 40283;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LOCK = 2'd1,
        ST_SLIP = 2'd2,
        ST_WAIT = 2'd3
    } lock_state_e;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_block_lock_ber_mon.sv
// rtl/pcs_rx_block_lock_ber_mon.sv - windowed invalid-header counter driving hi_ber
module pcs_rx_ber_mon #(
    parameter int BER_WINDOW = 40283,
    parameter int BER_THRESH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic block_lock,
    input  logic hdr_valid,
    input  logic sh_invalid,
    output logic hi_ber
);

    localparam int TW = $clog2(BER_WINDOW);
    localparam int CW = $clog2(BER_THRESH + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BER_WINDOW - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(BER_THRESH);

    logic [TW-1:0] timer;
    logic [CW-1:0] ber_cnt;
    logic [CW-1:0] cnt_inc;
    logic          wrap;

    // cnt_inc includes a header landing on the wrap cycle so it lands in the ending window
    always_comb begin
        wrap    = (timer == TIMER_LAST);
        cnt_inc = ber_cnt;
        if (hdr_valid && sh_invalid && (ber_cnt < CNT_SAT)) begin
            cnt_inc = ber_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            ber_cnt <= '0;
            hi_ber  <= 1'b0;
        end else if (!block_lock) begin
            timer   <= '0;
            ber_cnt <= '0;
            hi_ber  <= 1'b0;
        end else if (wrap) begin
            timer   <= '0;
            ber_cnt <= '0;
            hi_ber  <= (cnt_inc >= CNT_SAT);
        end else begin
            timer   <= timer + 1'b1;
            ber_cnt <= cnt_inc;
            if (ber_cnt >= CNT_SAT) begin
                hi_ber <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcs_rx_block_lock.sv
// rtl/pcs_rx_block_lock.sv - sync-header block lock FSM with slip request and BER monitor
module pcs_rx_block_lock
    import gtype::*;
#(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 66,
    parameter int BER_WINDOW   = BER_WINDOW_322M,
    parameter int BER_THRESH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] hdr,
    input  logic       hdr_valid,
    output logic       pma_slip,
    output logic       block_lock,
    output logic       hi_ber
);

    localparam int SCW = $clog2(SH_CNT_MAX + 1);
    localparam int ICW = $clog2(SH_INVLD_MAX + 1);
    localparam int WCW = $clog2(SLIP_WAIT + 1);
    localparam logic [SCW-1:0] SH_CNT_TOP   = SCW'(SH_CNT_MAX);
    localparam logic [ICW-1:0] SH_INVLD_TOP = ICW'(SH_INVLD_MAX);
    localparam logic [WCW-1:0] WAIT_LOAD    = WCW'(SLIP_WAIT);

    lock_state_e    state, state_d;
    logic [SCW-1:0] sh_cnt, sh_cnt_d, cnt_inc;
    logic [ICW-1:0] sh_invld_cnt, sh_invld_cnt_d, invld_inc;
    logic [WCW-1:0] wait_cnt, wait_cnt_d;
    logic           pma_slip_d, block_lock_d;
    logic           sh_invalid;

    // Counter limits are tested on the incremented value so the deciding header acts on its own edge
    always_comb begin
        sh_invalid     = !sh_is_valid(hdr);
        cnt_inc        = sh_cnt + 1'b1;
        invld_inc      = sh_invld_cnt + ICW'(sh_invalid);
        state_d        = state;
        sh_cnt_d       = sh_cnt;
        sh_invld_cnt_d = sh_invld_cnt;
        wait_cnt_d     = wait_cnt;
        pma_slip_d     = (state == ST_SLIP);
        block_lock_d   = (state == ST_LOCK);

        case (state)
            ST_HUNT: begin
                if (hdr_valid) begin
                    if (sh_invalid) begin
                        state_d = ST_SLIP;
                    end else if (cnt_inc == SH_CNT_TOP) begin
                        state_d        = ST_LOCK;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d = cnt_inc;
                    end
                end
            end
            ST_LOCK: begin
                if (hdr_valid) begin
                    // losing lock outranks the end-of-window clear
                    if (invld_inc == SH_INVLD_TOP) begin
                        state_d = ST_SLIP;
                    end else if (cnt_inc == SH_CNT_TOP) begin
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d       = cnt_inc;
                        sh_invld_cnt_d = invld_inc;
                    end
                end
            end
            ST_SLIP: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt <= WCW'(1)) begin
                    wait_cnt_d     = '0;
                    sh_cnt_d       = '0;
                    sh_invld_cnt_d = '0;
                    state_d        = ST_HUNT;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_HUNT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
            pma_slip     <= 1'b0;
            block_lock   <= 1'b0;
        end else begin
            state        <= state_d;
            sh_cnt       <= sh_cnt_d;
            sh_invld_cnt <= sh_invld_cnt_d;
            wait_cnt     <= wait_cnt_d;
            pma_slip     <= pma_slip_d;
            block_lock   <= block_lock_d;
        end
    end

    pcs_rx_ber_mon #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .block_lock (block_lock),
        .hdr_valid  (hdr_valid),
        .sh_invalid (sh_invalid),
        .hi_ber     (hi_ber)
    );

endmodule
